// File: rtl/phantom_clock.sv
// Phantom real-time clock: unlocks on a 64-bit serial pattern on D0 and then
// steals 64 accesses to stream BCD time in or out. Optional calendar: PHANTOM_CALENDAR_EN.
module phantom_clock #(
   parameter int TICK_DIV = 71591
) (
   input  logic C7M,
   input  logic RES,
   input  logic nCS,
   input  logic nWE,
   input  logic DIN,
   output logic RAMROMCSgb,
   output logic DOUT,
   output logic DOE,
   output logic ACTIVE
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX    = DW'(TICK_DIV - 1);
   localparam logic [63:0]   PATTERN    = 64'h5CA33AC5_5CA33AC5;
   localparam logic [63:0]   RESET_TIME = 64'h00_01_01_01_00_00_00_00;

   typedef enum logic {HUNT, XFER} state_t;

   state_t         state, state_next;
   logic           prev_ncs, acc_open, wes, ds;
   logic [5:0]     ptr, idx;
   logic [63:0]    snap, shadow, shadow_next, time_reg, time_next;
   logic [DW-1:0]  div;
   logic           acc_end, is_write, match, gate, tick, commit;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
   endfunction

`ifdef PHANTOM_CALENDAR_EN
   logic [7:0] date_max;

   // Divisible by four in BCD: even tens with units 0/4/8, odd tens with 2/6.
   function automatic logic leap_year(input logic [7:0] y);
      if (y[4])
         leap_year = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
      else
         leap_year = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
   endfunction
`endif

   // An access only counts if its falling edge was seen after a high cycle.
   assign acc_end    = nCS & ~prev_ncs & acc_open;
   assign is_write   = ~wes;
   assign match      = (ds == PATTERN[ptr]);
   assign gate       = (state == XFER);
   assign tick       = (div == DIV_MAX);
   assign commit     = acc_end & gate & (idx == 6'd63) & is_write;

   assign RAMROMCSgb = ~nCS & ~gate;
   assign DOE        = gate & ~nCS & nWE;
   assign DOUT       = gate & snap[idx];
   assign ACTIVE     = gate;

   always_comb begin
      state_next = state;
      if (acc_end) begin
         case (state)
            HUNT:    if (is_write && match && ptr == 6'd63) state_next = XFER;
            XFER:    if (idx == 6'd63) state_next = HUNT;
            default: state_next = HUNT;
         endcase
      end
   end

   always_comb begin
      shadow_next = shadow;
      if (is_write)
         shadow_next[idx] = ds;
   end

   // Rollover compares for equality so out-of-range values still wrap eventually.
   always_comb begin
      time_next = time_reg;
`ifdef PHANTOM_CALENDAR_EN
      case (time_reg[55:48])
         8'h02:                      date_max = leap_year(time_reg[63:56]) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: date_max = 8'h30;
         default:                    date_max = 8'h31;
      endcase
`endif
      if (tick) begin
         time_next[7:0] = bcd_inc(time_reg[7:0]);
         if (time_reg[7:0] == 8'h99) begin
            time_next[7:0]   = 8'h00;
            time_next[15:8]  = bcd_inc(time_reg[15:8]);
            if (time_reg[15:8] == 8'h59) begin
               time_next[15:8]  = 8'h00;
               time_next[23:16] = bcd_inc(time_reg[23:16]);
               if (time_reg[23:16] == 8'h59) begin
                  time_next[23:16] = 8'h00;
                  time_next[31:24] = bcd_inc(time_reg[31:24]);
                  if (time_reg[31:24] == 8'h23) begin
                     time_next[31:24] = 8'h00;
                     time_next[39:32] = (time_reg[39:32] == 8'h07) ? 8'h01 : bcd_inc(time_reg[39:32]);
`ifdef PHANTOM_CALENDAR_EN
                     time_next[47:40] = bcd_inc(time_reg[47:40]);
                     if (time_reg[47:40] == date_max) begin
                        time_next[47:40] = 8'h01;
                        time_next[55:48] = bcd_inc(time_reg[55:48]);
                        if (time_reg[55:48] == 8'h12) begin
                           time_next[55:48] = 8'h01;
                           time_next[63:56] = (time_reg[63:56] == 8'h99) ? 8'h00 : bcd_inc(time_reg[63:56]);
                        end
                     end
`endif
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge C7M) begin
      if (RES)
         state <= HUNT;
      else
         state <= state_next;
   end

   always_ff @(posedge C7M) begin
      if (RES) begin
         prev_ncs <= 1'b0;
         acc_open <= 1'b0;
         wes      <= 1'b1;
         ds       <= 1'b0;
         ptr      <= 6'd0;
         idx      <= 6'd0;
         snap     <= 64'd0;
         shadow   <= 64'd0;
         div      <= '0;
         time_reg <= RESET_TIME;
      end else begin
         prev_ncs <= nCS;
         if (!nCS) begin
            wes <= nWE;
            ds  <= DIN;
            if (prev_ncs)
               acc_open <= 1'b1;
         end else if (acc_end) begin
            acc_open <= 1'b0;
         end

         if (acc_end) begin
            if (!gate) begin
               if (is_write && match) begin
                  if (ptr == 6'd63) begin
                     ptr    <= 6'd0;
                     idx    <= 6'd0;
                     snap   <= time_reg;
                     shadow <= time_reg;
                  end else begin
                     ptr <= ptr + 6'd1;
                  end
               end else if (is_write) begin
                  ptr <= (ds == PATTERN[0]) ? 6'd1 : 6'd0;
               end else begin
                  ptr <= 6'd0;
               end
            end else begin
               shadow <= shadow_next;
               idx    <= idx + 6'd1;
               if (idx == 6'd63)
                  ptr <= 6'd0;
            end
         end

         // A commit replaces the live time and swallows a coincident tick.
         if (commit) begin
            time_reg <= shadow_next;
            div      <= '0;
         end else begin
            time_reg <= time_next;
            div      <= tick ? '0 : div + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_phantom_clock.sv
// Scoreboard bench for phantom_clock: unlock sequences, time write/read-back
// and tick rollover, with calendar expectations under PHANTOM_CALENDAR_EN.
module tb_phantom_clock;

   localparam int TD = 1000;

   logic C7M = 1'b0;
   logic RES = 1'b1;
   logic nCS = 1'b1;
   logic nWE = 1'b1;
   logic DIN = 1'b0;
   logic RAMROMCSgb, DOUT, DOE, ACTIVE;

   int vectors = 0;
   int miscompares = 0;
   bit expQ[$];
   bit [63:0] pat = 64'h5CA33AC5_5CA33AC5;
   bit [63:0] resetTime = 64'h00_01_01_01_00_00_00_00;
   bit dout, doe, cs;

   always #5 C7M = ~C7M;

   phantom_clock #(.TICK_DIV(TD)) dut (
      .C7M(C7M),
      .RES(RES),
      .nCS(nCS),
      .nWE(nWE),
      .DIN(DIN),
      .RAMROMCSgb(RAMROMCSgb),
      .DOUT(DOUT),
      .DOE(DOE),
      .ACTIVE(ACTIVE)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One access: two cycles low (sampled on the second), then high until the end is processed.
   task automatic applyStimulus(input bit isWrite, input bit d, output bit o, output bit oe, output bit sel);
      @(posedge C7M); #1;
      nCS = 1'b0; nWE = ~isWrite; DIN = d;
      @(posedge C7M); #1;
      o = DOUT; oe = DOE; sel = RAMROMCSgb;
      @(posedge C7M); #1;
      nCS = 1'b1; nWE = 1'b1;
      @(posedge C7M); #1;
   endtask

   task automatic doReset();
      @(posedge C7M); #1;
      RES = 1'b1; nCS = 1'b1; nWE = 1'b1;
      repeat (2) @(posedge C7M);
      #1 RES = 1'b0;
      @(posedge C7M); #1;
   endtask

   task automatic unlock(input string tag);
      bit o, oe, sel;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b1, pat[i], o, oe, sel);
         if (i == 0) checkOutput({tag, "_hunt_cs"}, sel, 1'b1);
      end
      checkOutput({tag, "_unlocked"}, ACTIVE, 1'b1);
   endtask

   task automatic readStream(input logic [63:0] t, input string tag);
      bit o, oe, sel;
      for (int i = 0; i < 64; i++) begin
         expQ.push_back(t[i]);
         applyStimulus(1'b0, 1'b0, o, oe, sel);
         checkOutput($sformatf("%s_bit%0d", tag, i), o, expQ.pop_front());
         if (i == 0) begin
            checkOutput({tag, "_gated_cs"}, sel, 1'b0);
            checkOutput({tag, "_doe"}, oe, 1'b1);
         end
      end
      checkOutput({tag, "_relock"}, ACTIVE, 1'b0);
      applyStimulus(1'b0, 1'b0, o, oe, sel);
      checkOutput({tag, "_mem_cs"}, sel, 1'b1);
      checkOutput({tag, "_mem_doe"}, oe, 1'b0);
   endtask

   task automatic readTime(input logic [63:0] t, input string tag);
      unlock(tag);
      readStream(t, tag);
   endtask

   task automatic writeTime(input logic [63:0] t, input string tag);
      bit o, oe, sel;
      unlock(tag);
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b1, t[i], o, oe, sel);
         if (i == 0) checkOutput({tag, "_wr_cs"}, sel, 1'b0);
      end
      checkOutput({tag, "_commit_gate"}, ACTIVE, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] exp1, exp2, exp3;
`ifdef PHANTOM_CALENDAR_EN
      exp1 = 64'h00_01_02_04_00_00_00_00;
      exp2 = 64'h04_02_29_02_00_00_00_00;
      exp3 = 64'h03_03_01_02_00_00_00_00;
`else
      exp1 = 64'h00_01_01_04_00_00_00_00;
      exp2 = 64'h04_02_28_02_00_00_00_00;
      exp3 = 64'h03_02_28_02_00_00_00_00;
`endif

      $display("[TB] reset state");
      doReset();
      checkOutput("rst_active", ACTIVE, 1'b0);
      checkOutput("rst_doe", DOE, 1'b0);
      checkOutput("rst_dout", DOUT, 1'b0);
      checkOutput("rst_cs_idle", RAMROMCSgb, 1'b0);
      applyStimulus(1'b0, 1'b0, dout, doe, cs);
      checkOutput("rst_cs_access", cs, 1'b1);
      checkOutput("rst_doe_access", doe, 1'b0);

      $display("[TB] unlock and read reset time");
      readTime(resetTime, "rd0");

      $display("[TB] interrupted pattern");
      doReset();
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, pat[i], dout, doe, cs);
      applyStimulus(1'b0, 1'b0, dout, doe, cs);
      for (int i = 0; i < 63; i++) applyStimulus(1'b1, pat[i], dout, doe, cs);
      checkOutput("intr_not_yet", ACTIVE, 1'b0);
      applyStimulus(1'b1, pat[63], dout, doe, cs);
      checkOutput("intr_unlocked", ACTIVE, 1'b1);
      readStream(resetTime, "intr");

      $display("[TB] day rollover");
      doReset();
      writeTime(64'h00_01_01_03_23_59_59_99, "wr1");
      repeat (TD) @(posedge C7M);
      #1;
      readTime(exp1, "tick1");

      $display("[TB] february leap year");
      doReset();
      writeTime(64'h04_02_28_01_23_59_59_99, "wr2");
      repeat (TD) @(posedge C7M);
      #1;
      readTime(exp2, "leap");

      $display("[TB] february non-leap year");
      doReset();
      writeTime(64'h03_02_28_01_23_59_59_99, "wr3");
      repeat (TD) @(posedge C7M);
      #1;
      readTime(exp3, "noleap");

      $display("[TB] reset during write transfer");
      doReset();
      unlock("mid");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, dout, doe, cs);
      @(posedge C7M); #1;
      RES = 1'b1;
      @(posedge C7M); #1;
      RES = 1'b0;
      checkOutput("mid_gate_drop", ACTIVE, 1'b0);
      readTime(resetTime, "mid");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
